rq_poly_adder: RTL and testbench

Streaming coefficient-wise adder for polynomials in Rq, with q = 2^COEF_W. It accepts LANES coefficient pairs per beat over a valid/ready handshake and adds each pair mod q in a 2-stage split-carry pipeline. It counts beats so that the final beat of each N-coefficient polynomial is tagged. It sits between the polynomial memory read ports and the write-back path of the Add_in_Rq datapath.

---
 rtl/rq_add_pkg.sv | 29 ++
 rtl/rq_coef_add_stage.sv | 55 +++++
 rtl/rq_poly_adder.sv | 95 +++++++++
 tb/tb_rq_poly_adder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rq_add_pkg.sv
// rtl/rq_add_pkg.sv - shared types, defaults and helpers for the Rq polynomial adder
// Purpose: default coefficient width / polynomial length, the coefficient type,
//          the beats-per-polynomial helper and the stage-1 register layout.
// Ports:   none (package).
package rq_add_pkg;

  localparam int COEF_W_DEFAULT = 13;
  localparam int N_DEFAULT      = 701;

  typedef logic [COEF_W_DEFAULT-1:0] coef_t;

  // Stage-1 register contents for the default coefficient width.
  localparam int LO_W_DEFAULT = COEF_W_DEFAULT / 2;
  localparam int HI_W_DEFAULT = COEF_W_DEFAULT - LO_W_DEFAULT;

  typedef struct packed {
    logic [LO_W_DEFAULT-1:0] lo;
    logic                    c;
    logic [HI_W_DEFAULT-1:0] a_hi;
    logic [HI_W_DEFAULT-1:0] b_hi;
    logic                    valid;
  } s1_t;

  // Number of beats needed to carry n coefficients, lanes at a time.
  function automatic int beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/rq_coef_add_stage.sv
// rtl/rq_coef_add_stage.sv - one lane of the 2-stage split-carry mod-2^COEF_W adder
// Purpose: stage 1 adds the low halves (plus carry-in) and registers the high
//          halves; stage 2 finishes the high half and drops the top carry.
// Ports:   clk, rst (sync active-high), en (advance both stages),
//          a, b (operands), sub (1: b is inverted and carry-in is 1),
//          sum (registered result, a +/- b mod 2^COEF_W).
module rq_coef_add_stage
  import rq_add_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  input  logic              sub,
  output logic [COEF_W-1:0] sum
);

  localparam int LO_W = COEF_W / 2;
  localparam int HI_W = COEF_W - LO_W;

  logic [COEF_W-1:0] b_eff;
  logic [LO_W:0]     lo_sum;
  logic [LO_W-1:0]   lo_q;
  logic              c_q;
  logic [HI_W-1:0]   a_hi_q;
  logic [HI_W-1:0]   b_hi_q;
  logic [HI_W-1:0]   hi;

  // Two's-complement subtraction: a + ~b + 1.
  assign b_eff  = sub ? ~b : b;
  assign lo_sum = {1'b0, a[LO_W-1:0]} + {1'b0, b_eff[LO_W-1:0]} + (LO_W+1)'(sub);

  // Truncation to HI_W bits discards the carry out, giving the mod-q wrap.
  assign hi = a_hi_q + b_hi_q + HI_W'(c_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q   <= '0;
      c_q    <= 1'b0;
      a_hi_q <= '0;
      b_hi_q <= '0;
      sum    <= '0;
    end else if (en) begin
      lo_q   <= lo_sum[LO_W-1:0];
      c_q    <= lo_sum[LO_W];
      a_hi_q <= a[COEF_W-1:LO_W];
      b_hi_q <= b_eff[COEF_W-1:LO_W];
      sum    <= {hi, lo_q};
    end
  end

endmodule

// File: rtl/rq_poly_adder.sv
// rtl/rq_poly_adder.sv - streaming coefficient-wise adder for polynomials in Rq, q = 2^COEF_W
// Purpose: accepts LANES coefficient pairs per beat, adds them mod q in a
//          2-stage pipeline and tags the final beat of every N-coefficient
//          polynomial. Optional macro RQ_SUB_EN adds a per-beat sub input.
// Ports:   clk, rst (sync active-high),
//          in_valid/in_ready/in1/in2 (input beat, lane k at [k*COEF_W +: COEF_W]),
//          sub (RQ_SUB_EN only; 1 selects in1 - in2),
//          out_valid/out_ready/out/out_last (result beat, last-beat tag).
module rq_poly_adder
  import rq_add_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEFAULT,
  parameter int N      = N_DEFAULT,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*COEF_W-1:0] in1,
  input  logic [LANES*COEF_W-1:0] in2,
`ifdef RQ_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*COEF_W-1:0] out,
  output logic                    out_last
);

  localparam int BEATS    = beats(N, LANES);
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  // First lane index that lies beyond N on the final beat.
  localparam int PAD_FROM = N - (BEATS - 1) * LANES;

  logic             adv;
  logic             last_tag;
  logic             beat_sub;
  logic [CNT_W-1:0] cnt;
  logic             s1_valid;
  logic             s1_last;

  // The whole pipeline moves as one unit whenever the output slot frees up.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign last_tag = (cnt == CNT_W'(BEATS - 1));

`ifdef RQ_SUB_EN
  assign beat_sub = sub;
`else
  assign beat_sub = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_last   <= in_valid & last_tag;
      out_valid <= s1_valid;
      out_last  <= s1_last;
      if (in_valid) begin
        cnt <= last_tag ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic              pad;
    logic [COEF_W-1:0] a;
    logic [COEF_W-1:0] b;

    // Zero operands give a zero result for both add (0+0) and sub (0+~0+1).
    assign pad = last_tag && (k >= PAD_FROM);
    assign a   = pad ? '0 : in1[k*COEF_W +: COEF_W];
    assign b   = pad ? '0 : in2[k*COEF_W +: COEF_W];

    rq_coef_add_stage #(
      .COEF_W(COEF_W)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .a   (a),
      .b   (b),
      .sub (beat_sub),
      .sum (out[k*COEF_W +: COEF_W])
    );
  end

endmodule

// File: tb/tb_rq_poly_adder.sv
// tb/tb_rq_poly_adder.sv - scoreboard bench for rq_poly_adder (LANES=1 and LANES=4 instances)
module tb_rq_poly_adder;

  localparam int W  = 13;
  localparam int N  = 701;
  localparam int B4 = (N + 3) / 4;

  typedef struct {
    logic [4*W-1:0] data;
    logic           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           v1, rdy1, ov1, or1, last1, sub1;
  logic [W-1:0]   a1, b1, o1;
  logic           v4, rdy4, ov4, or4, last4, sub4;
  logic [4*W-1:0] a4, b4, o4;

  exp_t q1[$];
  exp_t q4[$];
  int   lasts1[$];
  int   lasts4[$];
  int   cnt1, cnt4, obeat1, obeat4;
  int   total, bad;
  bit   acc1, acc4;

  rq_poly_adder #(.COEF_W(W), .N(N), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in1(a1), .in2(b1),
`ifdef RQ_SUB_EN
    .sub(sub1),
`endif
    .out_valid(ov1), .out_ready(or1), .out(o1), .out_last(last1)
  );

  rq_poly_adder #(.COEF_W(W), .N(N), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in1(a4), .in2(b4),
`ifdef RQ_SUB_EN
    .sub(sub4),
`endif
    .out_valid(ov4), .out_ready(or4), .out(o4), .out_last(last4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
`ifdef RQ_SUB_EN
    return s ? (a - b) : (a + b);
`else
    return a + b;
`endif
  endfunction

  // Called at a negedge with inputs already driven; scores one clock cycle.
  task automatic tick();
    exp_t e;
    #1;
    acc1 = v1 && rdy1;
    acc4 = v4 && rdy4;
    if (ov1 && or1) begin
      if (q1.size() == 0) chk("sb1_underflow", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("out1", 64'(o1), 64'(e.data[W-1:0]));
        chk("last1", 64'(last1), 64'(e.last));
      end
      if (last1) lasts1.push_back(obeat1);
      obeat1++;
    end
    if (ov4 && or4) begin
      if (q4.size() == 0) chk("sb4_underflow", 64'd1, 64'd0);
      else begin
        e = q4.pop_front();
        chk("out4", 64'(o4), 64'(e.data));
        chk("last4", 64'(last4), 64'(e.last));
      end
      if (last4) lasts4.push_back(obeat4);
      obeat4++;
    end
    if (acc1) begin
      e.data = '0;
      e.data[W-1:0] = op(a1, b1, sub1);
      e.last = (cnt1 == N - 1);
      q1.push_back(e);
      cnt1 = (cnt1 == N - 1) ? 0 : cnt1 + 1;
    end
    if (acc4) begin
      for (int k = 0; k < 4; k++) begin
        if (cnt4 == B4 - 1 && cnt4 * 4 + k >= N) e.data[k*W +: W] = '0;
        else e.data[k*W +: W] = op(a4[k*W +: W], b4[k*W +: W], sub4);
      end
      e.last = (cnt4 == B4 - 1);
      q4.push_back(e);
      cnt4 = (cnt4 == B4 - 1) ? 0 : cnt4 + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; v1 = 1'b0; v4 = 1'b0; or1 = 1'b1; or4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q1.delete(); q4.delete(); lasts1.delete(); lasts4.delete();
    cnt1 = 0; cnt4 = 0; obeat1 = 0; obeat4 = 0;
  endtask

  task automatic drain(input int n);
    v1 = 1'b0; v4 = 1'b0; or1 = 1'b1; or4 = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic feed1(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    v1 = 1'b1; a1 = a; b1 = b; sub1 = s; or1 = 1'b1;
    tick();
  endtask

  logic [W-1:0] bp_data[10];
  logic [W-1:0] held;
  logic         held_v;
  int           idx, cyc;

  initial begin
    rst = 1'b1; v1 = 1'b0; v4 = 1'b0; or1 = 1'b1; or4 = 1'b1;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0; sub1 = 1'b0; sub4 = 1'b0;
    total = 0; bad = 0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_out1", 64'(o1), 64'd0);
    chk("rst_last1", 64'(last1), 64'd0);
    chk("rst_ov4", 64'(ov4), 64'd0);
    chk("rst_out4", 64'(o4), 64'd0);
    chk("rst_rdy1", 64'(rdy1), 64'd1);

    // Wrap-around and plain sums
    feed1(13'd8191, 13'd1, 1'b0);
    feed1(13'd4095, 13'd4097, 1'b0);
    feed1(13'd100, 13'd23, 1'b0);
    for (int i = 0; i < 8; i++) feed1(W'($urandom_range(0, 8191)), W'($urandom_range(0, 8191)), 1'b0);
    drain(4);
    chk("sb1_empty_wrap", 64'(q1.size()), 64'd0);

`ifdef RQ_SUB_EN
    feed1(13'd0, 13'd1, 1'b1);
    feed1(13'd5, 13'd3, 1'b1);
    for (int i = 0; i < 10; i++) feed1(W'($urandom_range(0, 8191)), W'($urandom_range(0, 8191)), 1'(i % 2));
    drain(4);
    sub1 = 1'b0;
    chk("sb1_empty_sub", 64'(q1.size()), 64'd0);
`endif

    // Backpressure: out_ready low during stream cycles 3..7
    for (int i = 0; i < 10; i++) bp_data[i] = W'($urandom_range(0, 8191));
    idx = 0; cyc = 0; held = '0; held_v = 1'b0;
    while (idx < 10 && cyc < 40) begin
      v1 = 1'b1; a1 = bp_data[idx]; b1 = W'(idx * 37);
      or1 = !(cyc >= 3 && cyc <= 7);
      #1;
      if (cyc == 3) begin held = o1; held_v = ov1; end
      if (cyc >= 3 && cyc <= 7) begin
        chk("bp_in_ready", 64'(rdy1), 64'd0);
        chk("bp_out_stable", 64'(o1), 64'(held));
        chk("bp_ov_stable", 64'(ov1), 64'(held_v));
      end
      tick();
      if (acc1) idx++;
      cyc++;
    end
    chk("bp_all_sent", 64'(idx), 64'd10);
    drain(4);
    chk("bp_sb_empty", 64'(q1.size()), 64'd0);

    // Framing LANES=1: two back-to-back polynomials
    do_reset();
    for (int i = 0; i < 2 * N; i++) feed1(W'($urandom_range(0, 8191)), W'($urandom_range(0, 8191)), 1'b0);
    drain(4);
    chk("frame1_nlast", 64'(lasts1.size()), 64'd2);
    if (lasts1.size() == 2) begin
      chk("frame1_last0", 64'(lasts1[0]), 64'd700);
      chk("frame1_last1", 64'(lasts1[1]), 64'd1401);
    end
    chk("frame1_sb_empty", 64'(q1.size()), 64'd0);

    // Framing LANES=4 with all-ones operands, padding on the last beat
    do_reset();
    for (int i = 0; i < B4; i++) begin
      v4 = 1'b1; a4 = {4{13'd8191}}; b4 = {4{13'd8191}}; or4 = 1'b1;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      v4 = 1'b0;
      #1;
      if (ov4 && last4) chk("frame4_pad", 64'(o4[4*W-1:W]), 64'd0);
      tick();
    end
    drain(2);
    chk("frame4_nlast", 64'(lasts4.size()), 64'd1);
    if (lasts4.size() == 1) chk("frame4_lastpos", 64'(lasts4[0]), 64'd175);
    chk("frame4_sb_empty", 64'(q4.size()), 64'd0);

    // Mid-stream reset after beat 300
    do_reset();
    for (int i = 0; i <= 300; i++) feed1(W'($urandom_range(0, 8191)), W'($urandom_range(0, 8191)), 1'b0);
    do_reset();
    chk("mid_rst_ov", 64'(ov1), 64'd0);
    chk("mid_rst_last", 64'(last1), 64'd0);
    for (int i = 0; i < N; i++) feed1(W'($urandom_range(0, 8191)), W'($urandom_range(0, 8191)), 1'b0);
    drain(4);
    chk("mid_nlast", 64'(lasts1.size()), 64'd1);
    if (lasts1.size() == 1) chk("mid_lastpos", 64'(lasts1[0]), 64'd700);
    chk("mid_sb_empty", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
